// File: rtl/trap_integrator_mc.sv
// trap_integrator_mc
//   Time-multiplexed trapezoidal integrator serving CH channels.
//   Each channel keeps its previous sample and a signed accumulator.
//   Every accepted sample adds (prev + cur) * DT_MUL to that channel's accumulator.
//   The reported integral is acc >>> (DT_SHIFT + 1).
//   Pipeline: S1 forms the weighted pair sum, S2 does the accumulator
//   read-modify-write. A transfer in cycle t shows out_valid in cycle t+2.
//   Optional build macro TRAPINT_SAT_EN:
//     - the accumulator saturates instead of wrapping;
//     - ovf[ch] flags any clipping on that channel.
//   Without the macro the accumulator wraps and ovf is tied to 0.
module trap_integrator_mc #(
  parameter int CH       = 4,
  parameter int DW       = 16,
  parameter int MW       = 12,
  parameter int DT_MUL   = 10,
  parameter int DT_SHIFT = 0,
  parameter int AW       = 48,
  localparam int CW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW-1:0]        in_ch,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  output logic [CW-1:0]        out_ch,
  output logic signed [AW-1:0] out_data,
  output logic [CH-1:0]        ovf,
  output logic                 busy
);

  localparam int PW = DW + MW + 2;
  localparam logic signed [MW:0] MUL = (MW+1)'(DT_MUL);

  typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

  state_t                state_reg;
  logic [CW-1:0]         clr_idx_reg;

  // Per-channel state
  logic signed [DW-1:0]  prev_mem [CH];
  logic signed [AW-1:0]  acc_mem  [CH];
  logic [CH-1:0]         first_reg;

  // Pipeline registers
  logic                  s1_valid_reg;
  logic [CW-1:0]         s1_ch_reg;
  logic signed [PW-1:0]  s1_prod_reg;
  logic                  out_valid_reg;
  logic [CW-1:0]         out_ch_reg;
  logic signed [AW-1:0]  out_data_reg;

  logic                  ch_ok;
  logic                  s1_take;
  logic signed [DW-1:0]  prev_rd;
  logic signed [DW:0]    s1_sum;
  logic signed [PW-1:0]  s1_prod_next;
  logic signed [AW-1:0]  acc_rd;
  logic signed [AW-1:0]  acc_new;
  logic signed [AW-1:0]  out_next;

`ifdef TRAPINT_SAT_EN
  localparam int SW = ((AW > PW) ? AW : PW) + 1;
  logic signed [SW-1:0]  add_wide;
  logic                  clip;
  logic [CH-1:0]         ovf_reg;
`endif

  // New samples are refused outside RUN and in any cycle that clears.
  assign in_ready = (state_reg == RUN) && !clr;
  // Out-of-range channels are accepted but never enter the pipeline.
  assign ch_ok    = (32'(in_ch) < CH);
  assign s1_take  = in_valid && in_ready && ch_ok;

  // Control FSM: run gating plus the one-channel-per-cycle clear sweep
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_reg   <= IDLE;
      clr_idx_reg <= '0;
    end else if (clr) begin
      state_reg   <= CLEAR;
      clr_idx_reg <= '0;
    end else begin
      case (state_reg)
        IDLE:    if (en) state_reg <= RUN;
        RUN:     if (!en) state_reg <= IDLE;
        CLEAR: begin
          if (clr_idx_reg == CW'(CH - 1)) begin
            state_reg <= en ? RUN : IDLE;
          end else begin
            clr_idx_reg <= clr_idx_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // S1 combinational: pair sum and weighting; first sample contributes nothing
  always_comb begin
    prev_rd      = prev_mem[in_ch];
    s1_sum       = (DW+1)'(prev_rd) + (DW+1)'(in_data);
    s1_prod_next = PW'(s1_sum) * PW'(MUL);
    if (first_reg[in_ch]) begin
      s1_prod_next = '0;
    end
  end

  // S2 combinational: accumulator update (wrapping or saturating) and output scaling
  always_comb begin
    acc_rd = acc_mem[s1_ch_reg];
`ifdef TRAPINT_SAT_EN
    add_wide = SW'(acc_rd) + SW'(s1_prod_reg);
    // In range only if every bit from AW-1 upward matches the sign
    clip = (add_wide[SW-1:AW-1] != {(SW-AW+1){add_wide[SW-1]}});
    if (clip) begin
      acc_new = add_wide[SW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      acc_new = add_wide[AW-1:0];
    end
`else
    acc_new = acc_rd + AW'(s1_prod_reg);
`endif
    out_next = acc_new >>> (DT_SHIFT + 1);
  end

  // Datapath: pipeline advance, per-channel state updates and clear sweep
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      s1_valid_reg  <= 1'b0;
      s1_ch_reg     <= '0;
      s1_prod_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      out_data_reg  <= '0;
      first_reg     <= '1;
      for (int i = 0; i < CH; i++) begin
        prev_mem[i] <= '0;
        acc_mem[i]  <= '0;
      end
`ifdef TRAPINT_SAT_EN
      ovf_reg       <= '0;
`endif
    end else begin
      // clr drops whatever is in flight, including a result about to register
      s1_valid_reg  <= s1_take;
      out_valid_reg <= s1_valid_reg && !clr;

      if (s1_take) begin
        s1_ch_reg          <= in_ch;
        s1_prod_reg        <= s1_prod_next;
        prev_mem[in_ch]    <= in_data;
        first_reg[in_ch]   <= 1'b0;
      end

      if (s1_valid_reg && !clr) begin
        acc_mem[s1_ch_reg] <= acc_new;
        out_ch_reg         <= s1_ch_reg;
        out_data_reg       <= out_next;
`ifdef TRAPINT_SAT_EN
        if (clip) begin
          ovf_reg[s1_ch_reg] <= 1'b1;
        end
`endif
      end

      // No transfers or S2 work can coincide with the sweep
      if ((state_reg == CLEAR) && !clr) begin
        prev_mem[clr_idx_reg]  <= '0;
        acc_mem[clr_idx_reg]   <= '0;
        first_reg[clr_idx_reg] <= 1'b1;
`ifdef TRAPINT_SAT_EN
        ovf_reg[clr_idx_reg]   <= 1'b0;
`endif
      end
    end
  end

`ifdef TRAPINT_SAT_EN
  assign ovf = ovf_reg;
`else
  assign ovf = '0;
`endif

  assign out_valid = out_valid_reg && !clr;
  assign out_ch    = out_ch_reg;
  assign out_data  = out_data_reg;
  assign busy      = (state_reg != IDLE) || s1_valid_reg;

endmodule
